// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: hazard priority, HALT drain and halted hold.
// Optional stall/flush statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_halt,
  input  logic        idex_valid,
  input  logic        idex_memread,
  input  logic [2:0]  idex_wr_reg,
  input  logic        ex_redirect,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] DCNT_INIT = 2'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       load_use;

  // R0 is compared like any other register; the register file decides its meaning.
  assign load_use = idex_valid & idex_memread & id_valid &
                    ((id_rs_used & (id_rs == idex_wr_reg)) |
                     (id_rt_used & (id_rt == idex_wr_reg)));

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
      dcnt_d      = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (dmem_stall) begin
            // EX keeps presenting any redirect, so it is picked up once memory is ready.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (imem_stall) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
          if (id_valid && id_halt && !dmem_stall && !ex_redirect && !load_use) begin
            state_d = DRAIN;
            dcnt_d  = DCNT_INIT;
          end
        end
        DRAIN: begin
          if (dmem_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
          end else if (ex_redirect) begin
            // HALT was on the wrong path; resume normal fetch from the target.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            dcnt_d     = 2'd0;
          end else begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            if (dcnt_q == 2'd0) begin
              state_d = HALTED;
            end else begin
              dcnt_d = dcnt_q - 2'd1;
            end
          end
        end
        HALTED: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
          halted   = 1'b1;
        end
        default: begin
          state_d = RUN;
          dcnt_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      dcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        run_stall;
  logic        redirect_taken;

  assign run_stall      = (state_q == RUN) & ~pc_en & ~rst;
  assign redirect_taken = ~rst & ~dmem_stall & ex_redirect &
                          ((state_q == RUN) | (state_q == DRAIN));

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (run_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (redirect_taken && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 16'h0000;
      flush_count_q  <= 16'h0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 16'h0000;
  assign flush_count  = 16'h0000;
`endif

endmodule
